// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: header-driven audio clip player feeding a serial shifter from a sync-read ROM.
// Ports: clk/rst (sync, active-high); en freezes all state; audio_index selects the clip header
// address [14:0] (bit 15 = loop flag); stop aborts playback; shft_ready/shft_load/shft_data form the
// shifter handshake; rom_addr/rom_data drive the audio ROM (one-clock read latency); ready/busy/done
// report status.
// Optional feature: define AUDIO_LOOP_EN to honour the loop flag (clip restarts instead of ending).
module audio_stream_ctrl #(
   parameter int         ROM_ADDR_W    = 13,
   parameter int         ROM_DATA_W    = 8,
   parameter int         SAMPLE_PERIOD = 2048,
   parameter int         SHFT_W        = 76,
   parameter logic [3:0] SHFT_CMD      = 4'h9,
   parameter int         SAMPLE_LSB    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [15:0]           audio_index,
   input  logic                  stop,
   input  logic                  shft_ready,
   output logic [SHFT_W-1:0]     shft_data,
   output logic                  shft_load,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [ROM_DATA_W-1:0] rom_data,
   output logic                  ready,
   output logic                  busy,
   output logic                  done
);
`ifdef AUDIO_LOOP_EN
   localparam logic LOOP_EN = 1'b1;
`else
   localparam logic LOOP_EN = 1'b0;
`endif
   localparam int CW = $clog2(SAMPLE_PERIOD);
   typedef enum logic [2:0] {IDLE, H0, H1, H2, H3, SEND, WAIT} state_t;
   state_t state, state_n;
   logic [ROM_ADDR_W-1:0] idx, start, ptr, start_c;
   logic [15:0] size, sent;
   logic [7:0] addr_hi;
   logic [CW-1:0] wait_cnt;
   logic looping, wait_done, clip_end;
   assign start_c   = ROM_ADDR_W'({addr_hi, rom_data[7:0]});
   assign wait_done = wait_cnt == CW'(SAMPLE_PERIOD - 2);
   assign clip_end  = sent == size;
   assign shft_load = (state == SEND) & shft_ready & en & ~stop;
   assign shft_data = (state == SEND) ? ({SHFT_CMD, {(SHFT_W-4){1'b0}}} | (SHFT_W'(rom_data) << SAMPLE_LSB)) : '0;
   assign ready     = (state == IDLE) & en & ~rst;
   assign busy      = state != IDLE;
   always_comb begin
      state_n  = state;
      done     = 1'b0;
      rom_addr = '0;
      case (state)
         IDLE: begin
            rom_addr = audio_index[ROM_ADDR_W-1:0];
            state_n  = (audio_index[14:0] != '0) ? H0 : IDLE;
         end
         H0: begin
            rom_addr = idx + ROM_ADDR_W'(1);
            state_n  = H1;
         end
         H1: begin
            rom_addr = idx + ROM_ADDR_W'(2);
            state_n  = H2;
         end
         H2: begin
            rom_addr = idx + ROM_ADDR_W'(3);
            state_n  = H3;
         end
         H3: begin
            // start address goes straight to the ROM so the first sample is ready in SEND
            rom_addr = start_c;
            state_n  = (size == '0) ? IDLE : SEND;
            done     = size == '0;
         end
         SEND: begin
            rom_addr = ptr;
            state_n  = shft_ready ? WAIT : SEND;
         end
         WAIT: begin
            // on a looping restart prefetch the clip start during the last WAIT clock
            rom_addr = (wait_done & clip_end & looping) ? start : ptr;
            state_n  = !wait_done ? WAIT : (clip_end & ~looping) ? IDLE : SEND;
            done     = wait_done & clip_end & ~looping;
         end
         default: state_n = IDLE;
      endcase
      if (stop) begin
         state_n = IDLE;
         done    = 1'b0;
      end
      if (!en) begin
         state_n = state;
         done    = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         looping  <= 1'b0;
         size     <= '0;
         addr_hi  <= '0;
         start    <= '0;
         ptr      <= '0;
         sent     <= '0;
         wait_cnt <= '0;
      end else if (en) begin
         state <= state_n;
         case (state)
            IDLE: begin
               idx     <= audio_index[ROM_ADDR_W-1:0];
               looping <= audio_index[15] & LOOP_EN;
            end
            H0: size[15:8] <= rom_data[7:0];
            H1: size[7:0]  <= rom_data[7:0];
            H2: addr_hi    <= rom_data[7:0];
            H3: begin
               start <= start_c;
               ptr   <= start_c;
               sent  <= '0;
            end
            SEND: if (shft_load) begin
               ptr      <= ptr + ROM_ADDR_W'(1);
               sent     <= sent + 16'd1;
               wait_cnt <= '0;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + CW'(1);
               if (wait_done & clip_end & looping) begin
                  ptr  <= start;
                  sent <= '0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
